// File: rtl/bomb_pkg.sv
// -----------------------------------------------------------------------------
// bomb_pkg
// Shared definitions for the bomb/blast logic and the blast matrix bitmap:
//   - bomb_state_e      : controller FSM states
//   - TILE_SIZE         : playfield tile edge in pixels (bomb snaps to this grid)
//   - BLAST_HALF_SPAN   : offset from bomb tile origin to 5x5 blast window origin
//   - CROSS/VERT/HORIZ  : blast pattern encodings consumed by the bitmap
//   - helper functions for grid snap, clamped blast origin, pattern sanitising
// -----------------------------------------------------------------------------
package bomb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        PREP     = 3'd2,
        BLAST    = 3'd3,
        COOLDOWN = 3'd4
    } bomb_state_e;

    localparam int unsigned COORD_W         = 11;
    localparam int unsigned FRAME_CNT_W     = 8;
    localparam int unsigned TILE_SIZE       = 32;
    localparam int unsigned BLAST_HALF_SPAN = 64;

    localparam logic [2:0] CROSS = 3'd0;
    localparam logic [2:0] VERT  = 3'd1;
    localparam logic [2:0] HORIZ = 3'd2;

    // Align a pixel coordinate down to the tile grid.
    function automatic logic [COORD_W-1:0] snap_to_tile(input logic [COORD_W-1:0] pos);
        return pos & ~(COORD_W'(TILE_SIZE - 1));
    endfunction

    // Blast window origin two tiles up/left of the bomb, saturating at 0
    // so a bomb near the screen edge never wraps to the far side.
    function automatic logic [COORD_W-1:0] blast_origin(input logic [COORD_W-1:0] tile);
        logic [COORD_W-1:0] span;
        span = COORD_W'(BLAST_HALF_SPAN);
        if (tile >= span) begin
            return tile - span;
        end else begin
            return {COORD_W{1'b0}};
        end
    endfunction

    // Unknown pattern requests fall back to the cross.
    function automatic logic [2:0] legal_pattern(input logic [2:0] shape);
        if (shape > HORIZ) begin
            return CROSS;
        end else begin
            return shape;
        end
    endfunction

endpackage

// File: rtl/bomb_blast_controller_if.sv
// -----------------------------------------------------------------------------
// bomb_blast_controller_if
// Signal bundle between game logic (master) and the bomb controller (slave).
//   master -> slave : startOfFrame, place_bomb, detonate_now, playerX/Y, blast_shape
//   slave -> master : bomb_active, bombTopLeftX/Y, blast, blast_num, blastTopLeftX/Y
// -----------------------------------------------------------------------------
interface bomb_blast_controller_if;
    import bomb_pkg::*;

    logic               startOfFrame;
    logic               place_bomb;
    logic               detonate_now;
    logic [COORD_W-1:0] playerX;
    logic [COORD_W-1:0] playerY;
    logic [2:0]         blast_shape;

    logic               bomb_active;
    logic [COORD_W-1:0] bombTopLeftX;
    logic [COORD_W-1:0] bombTopLeftY;
    logic               blast;
    logic [2:0]         blast_num;
    logic [COORD_W-1:0] blastTopLeftX;
    logic [COORD_W-1:0] blastTopLeftY;

    modport master (
        output startOfFrame, place_bomb, detonate_now, playerX, playerY, blast_shape,
        input  bomb_active, bombTopLeftX, bombTopLeftY, blast, blast_num,
               blastTopLeftX, blastTopLeftY
    );

    modport slave (
        input  startOfFrame, place_bomb, detonate_now, playerX, playerY, blast_shape,
        output bomb_active, bombTopLeftX, bombTopLeftY, blast, blast_num,
               blastTopLeftX, blastTopLeftY
    );

endinterface

// File: rtl/bomb_blast_controller_counter.sv
// -----------------------------------------------------------------------------
// frame_down_counter
// Frame-based down counter used for fuse, blast and cooldown durations.
//   clk, resetN : clock, asynchronous active-low reset (count clears to 0)
//   load        : load load_value (has priority over tick)
//   load_value  : frames to count
//   tick        : one frame pulse; decrements while count is non-zero
//   hits_zero   : this tick takes the count from 1 to 0 (phase ends this edge)
// -----------------------------------------------------------------------------
module frame_down_counter
    import bomb_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   load,
    input  logic [FRAME_CNT_W-1:0] load_value,
    input  logic                   tick,
    output logic                   hits_zero
);

    logic [FRAME_CNT_W-1:0] count_r;

    // Flag the edge on which the count expires so the FSM can leave its state
    // on that same edge, keeping the output change one cycle after the tick.
    always_comb begin
        hits_zero = tick && (count_r == 8'd1);
    end

    // Count register: load, otherwise decrement on frame ticks, never below 0.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= load_value;
        end else if (tick && (count_r != 8'd0)) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/bomb_blast_controller.sv
// -----------------------------------------------------------------------------
// bomb_blast_controller
// Single-bomb lifecycle: placement -> fuse -> one-cycle prep -> blast -> cooldown.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : bomb_blast_controller_if.slave (frame pulse, placement/detonate
//            requests, player position, pattern in; bomb and blast
//            status/geometry out, all registered)
// Parameters FUSE_FRAMES, BLAST_FRAMES, COOLDOWN_FRAMES: 1..255 frames each.
// -----------------------------------------------------------------------------
module bomb_blast_controller
    import bomb_pkg::*;
#(
    parameter int unsigned FUSE_FRAMES     = 120,
    parameter int unsigned BLAST_FRAMES    = 30,
    parameter int unsigned COOLDOWN_FRAMES = 15
)
(
    input  logic                     clk,
    input  logic                     resetN,
    bomb_blast_controller_if.slave   bus
);

    localparam logic [FRAME_CNT_W-1:0] FUSE_LOAD  = FRAME_CNT_W'(FUSE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] BLAST_LOAD = FRAME_CNT_W'(BLAST_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] COOL_LOAD  = FRAME_CNT_W'(COOLDOWN_FRAMES);

    bomb_state_e            state_r;
    logic                   bomb_active_r;
    logic                   blast_r;
    logic [2:0]             blast_num_r;
    logic [COORD_W-1:0]     bomb_x_r;
    logic [COORD_W-1:0]     bomb_y_r;
    logic [COORD_W-1:0]     blast_x_r;
    logic [COORD_W-1:0]     blast_y_r;

    logic                   cnt_tick_s;
    logic                   cnt_load_s;
    logic [FRAME_CNT_W-1:0] cnt_value_s;
    logic                   expired_s;
    logic [COORD_W-1:0]     tile_x_s;
    logic [COORD_W-1:0]     tile_y_s;

    // Frame pulses only advance the timed states.
    always_comb begin
        case (state_r)
            ARMED, BLAST, COOLDOWN: cnt_tick_s = bus.startOfFrame;
            default:                cnt_tick_s = 1'b0;
        endcase
    end

    // Counter reloads: fuse on placement, blast length on leaving PREP,
    // cooldown length on the edge the blast expires.
    always_comb begin
        cnt_load_s  = 1'b0;
        cnt_value_s = 8'd0;
        case (state_r)
            IDLE: begin
                cnt_load_s  = bus.place_bomb;
                cnt_value_s = FUSE_LOAD;
            end
            PREP: begin
                cnt_load_s  = 1'b1;
                cnt_value_s = BLAST_LOAD;
            end
            BLAST: begin
                cnt_load_s  = expired_s;
                cnt_value_s = COOL_LOAD;
            end
            default: begin
                cnt_load_s  = 1'b0;
                cnt_value_s = 8'd0;
            end
        endcase
    end

    // Grid-snapped player position, latched only on placement.
    always_comb begin
        tile_x_s = snap_to_tile(bus.playerX);
        tile_y_s = snap_to_tile(bus.playerY);
    end

    frame_down_counter u_frame_cnt (
        .clk        (clk),
        .resetN     (resetN),
        .load       (cnt_load_s),
        .load_value (cnt_value_s),
        .tick       (cnt_tick_s),
        .hits_zero  (expired_s)
    );

    // Lifecycle FSM with registered status and geometry outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r       <= IDLE;
            bomb_active_r <= 1'b0;
            blast_r       <= 1'b0;
            blast_num_r   <= 3'd0;
            bomb_x_r      <= 11'd0;
            bomb_y_r      <= 11'd0;
            blast_x_r     <= 11'd0;
            blast_y_r     <= 11'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.place_bomb) begin
                        state_r       <= ARMED;
                        bomb_active_r <= 1'b1;
                        blast_num_r   <= legal_pattern(bus.blast_shape);
                        bomb_x_r      <= tile_x_s;
                        bomb_y_r      <= tile_y_s;
                        blast_x_r     <= blast_origin(tile_x_s);
                        blast_y_r     <= blast_origin(tile_y_s);
                    end
                end
                ARMED: begin
                    // Remote trigger and fuse expiry in the same cycle still
                    // produce a single move into PREP.
                    if (bus.detonate_now || expired_s) begin
                        state_r <= PREP;
                    end
                end
                PREP: begin
                    // blast_num has already been stable for this cycle.
                    state_r       <= BLAST;
                    bomb_active_r <= 1'b0;
                    blast_r       <= 1'b1;
                end
                BLAST: begin
                    if (expired_s) begin
                        state_r <= COOLDOWN;
                        blast_r <= 1'b0;
                    end
                end
                COOLDOWN: begin
                    if (expired_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    bomb_active_r <= 1'b0;
                    blast_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bomb_active   = bomb_active_r;
    assign bus.blast         = blast_r;
    assign bus.blast_num     = blast_num_r;
    assign bus.bombTopLeftX  = bomb_x_r;
    assign bus.bombTopLeftY  = bomb_y_r;
    assign bus.blastTopLeftX = blast_x_r;
    assign bus.blastTopLeftY = blast_y_r;

endmodule

// File: tb/tb_bomb_blast_controller.sv
// -----------------------------------------------------------------------------
// tb_bomb_blast_controller
// Directed lifecycle scenarios followed by randomized stimulus, every cycle
// compared against a frame-counting reference model of the bomb lifecycle.
// -----------------------------------------------------------------------------
module tb_bomb_blast_controller;

    localparam int FUSE  = 120;
    localparam int BLASTF = 30;
    localparam int COOLF  = 15;

    logic clk;
    logic resetN;

    bomb_blast_controller_if bus();

    bomb_blast_controller #(
        .FUSE_FRAMES     (FUSE),
        .BLAST_FRAMES    (BLASTF),
        .COOLDOWN_FRAMES (COOLF)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model: which phase of the bomb's life we are in and how many
    // frame pulses remain in that phase.
    typedef enum int {M_IDLE, M_FUSE, M_PREP, M_BLAST, M_COOL} m_phase_e;
    m_phase_e m_phase;
    int       m_frames_left;
    int       m_bomb_x, m_bomb_y, m_blast_x, m_blast_y, m_num;
    bit       m_active, m_blast;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int grid(input int p);
        return (p / 32) * 32;
    endfunction

    function automatic int window(input int b);
        return (b - 64 < 0) ? 0 : b - 64;
    endfunction

    function automatic void model_reset();
        m_phase = M_IDLE; m_frames_left = 0;
        m_bomb_x = 0; m_bomb_y = 0; m_blast_x = 0; m_blast_y = 0; m_num = 0;
        m_active = 1'b0; m_blast = 1'b0;
    endfunction

    function automatic void model_step();
        case (m_phase)
            M_IDLE: if (bus.place_bomb) begin
                m_bomb_x  = grid(int'(bus.playerX));
                m_bomb_y  = grid(int'(bus.playerY));
                m_blast_x = window(m_bomb_x);
                m_blast_y = window(m_bomb_y);
                m_num     = (int'(bus.blast_shape) > 2) ? 0 : int'(bus.blast_shape);
                m_frames_left = FUSE;
                m_active  = 1'b1;
                m_phase   = M_FUSE;
            end
            M_FUSE: begin
                if (bus.startOfFrame) m_frames_left--;
                if (bus.detonate_now || m_frames_left == 0) m_phase = M_PREP;
            end
            M_PREP: begin
                m_active = 1'b0; m_blast = 1'b1;
                m_frames_left = BLASTF;
                m_phase = M_BLAST;
            end
            M_BLAST: if (bus.startOfFrame) begin
                m_frames_left--;
                if (m_frames_left == 0) begin
                    m_blast = 1'b0; m_frames_left = COOLF; m_phase = M_COOL;
                end
            end
            M_COOL: if (bus.startOfFrame) begin
                m_frames_left--;
                if (m_frames_left == 0) m_phase = M_IDLE;
            end
            default: m_phase = M_IDLE;
        endcase
    endfunction

    task automatic compare_all();
        check_value("bomb_active", 32'(bus.bomb_active), 32'(m_active));
        check_value("blast", 32'(bus.blast), 32'(m_blast));
        check_value("blast_num", 32'(bus.blast_num), m_num);
        check_value("bomb_x", 32'(bus.bombTopLeftX), m_bomb_x);
        check_value("bomb_y", 32'(bus.bombTopLeftY), m_bomb_y);
        check_value("blast_x", 32'(bus.blastTopLeftX), m_blast_x);
        check_value("blast_y", 32'(bus.blastTopLeftY), m_blast_y);
    endtask

    // One clock: inputs already driven, model follows the edge, compare mid-cycle.
    task automatic tick(input bit sof, input bit pl, input bit det);
        bus.startOfFrame = sof;
        bus.place_bomb   = pl;
        bus.detonate_now = det;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // n frames, each one quiet cycle (optionally requesting placement) then a pulse.
    task automatic sof_frames(input int n, input bit pl);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, pl, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic set_player(input int x, input int y, input int shape);
        bus.playerX     = 11'(x);
        bus.playerY     = 11'(y);
        bus.blast_shape = 3'(shape);
    endtask

    initial begin
        resetN = 1'b0;
        bus.startOfFrame = 1'b0; bus.place_bomb = 1'b0; bus.detonate_now = 1'b0;
        set_player(0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        resetN = 1'b1;

        // Full fuse, vertical pattern.
        set_player(100, 70, 1);
        tick(1'b0, 1'b1, 1'b0);
        check_value("s1_bomb_x", 32'(bus.bombTopLeftX), 32'd96);
        check_value("s1_bomb_y", 32'(bus.bombTopLeftY), 32'd64);
        check_value("s1_blast_x", 32'(bus.blastTopLeftX), 32'd32);
        check_value("s1_blast_y", 32'(bus.blastTopLeftY), 32'd0);
        check_value("s1_num", 32'(bus.blast_num), 32'd1);
        sof_frames(FUSE, 1'b0);
        check_value("s1_prep_blast", 32'(bus.blast), 32'd0);
        check_value("s1_prep_active", 32'(bus.bomb_active), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        check_value("s1_blast_up", 32'(bus.blast), 32'd1);

        // Blast length and cooldown, placement requests ignored throughout.
        sof_frames(BLASTF, 1'b1);
        check_value("s2_blast_down", 32'(bus.blast), 32'd0);
        sof_frames(COOLF, 1'b1);
        check_value("s2_cool_no_bomb", 32'(bus.bomb_active), 32'd0);
        set_player(500, 300, 5);
        tick(1'b0, 1'b1, 1'b0);
        check_value("s2_accepted", 32'(bus.bomb_active), 32'd1);
        check_value("s2_num_fallback", 32'(bus.blast_num), 32'd0);

        // Remote detonation at fuse frame 10.
        sof_frames(10, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check_value("s3_prep_blast", 32'(bus.blast), 32'd0);
        check_value("s3_prep_active", 32'(bus.bomb_active), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        check_value("s3_blast_up", 32'(bus.blast), 32'd1);
        sof_frames(BLASTF + COOLF, 1'b0);

        // Clamp at the screen edge; detonate on the final fuse pulse.
        set_player(20, 40, 2);
        tick(1'b0, 1'b1, 1'b0);
        check_value("s4_bomb_x", 32'(bus.bombTopLeftX), 32'd0);
        check_value("s4_bomb_y", 32'(bus.bombTopLeftY), 32'd32);
        check_value("s4_blast_x", 32'(bus.blastTopLeftX), 32'd0);
        check_value("s4_blast_y", 32'(bus.blastTopLeftY), 32'd0);
        sof_frames(FUSE - 1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check_value("s5_single_prep", 32'(bus.blast), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check_value("s5_blast_up", 32'(bus.blast), 32'd1);
        check_value("s5_active_down", 32'(bus.bomb_active), 32'd0);

        // Asynchronous reset in the middle of the blast.
        sof_frames(5, 1'b0);
        resetN = 1'b0;
        #1;
        model_reset();
        check_value("s6_rst_blast", 32'(bus.blast), 32'd0);
        check_value("s6_rst_active", 32'(bus.bomb_active), 32'd0);
        compare_all();
        @(negedge clk);
        resetN = 1'b1;
        set_player(300, 200, 0);
        tick(1'b0, 1'b1, 1'b0);
        check_value("s6_replace_x", 32'(bus.blastTopLeftX), 32'd224);
        check_value("s6_replace_y", 32'(bus.blastTopLeftY), 32'd128);
        sof_frames(FUSE, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        sof_frames(BLASTF + COOLF, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_player(int'($urandom_range(0, 95)), int'($urandom_range(0, 95)),
                           int'($urandom_range(0, 7)));
            end else begin
                set_player(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                           int'($urandom_range(0, 7)));
            end
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
